// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU memory stage owns the port except during a
// two-cycle external access. Optional macro DMEM_ARB_ROUND_ROBIN_EN swaps starvation counting for alternation.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [2:0]    cpu_func3,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [31:0]   ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [31:0]   ext_rdata,
  output logic          mem_we,
  output logic [2:0]    mem_func3,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_starve_cnt
);

  // Handshake: ext_req is held with stable fields until ext_gnt (one cycle);
  // ext_rvalid pulses one cycle later, ext_rdata valid from then on.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT_ACC = 2'd1,
    EXT_RSP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          go_ext;
  logic          lat_req, lat_we;
  logic [31:0]   lat_addr, lat_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_ext;

  assign go_ext     = (state == IDLE) && ext_req && (!cpu_req || !last_ext);
  assign starve_cnt = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_ext <= 1'b0;
    else if ((state == IDLE) && (ext_req || cpu_req))
      last_ext <= go_ext;
  end
`else
  assign go_ext = (state == IDLE) && ext_req &&
                  (!cpu_req || (starve_cnt == CW'(STARVE_MAX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (go_ext)
      starve_cnt <= '0;
    else if ((state == IDLE) && ext_req && cpu_req && (starve_cnt != CW'(STARVE_MAX)))
      starve_cnt <= starve_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_ext) state_nxt = EXT_ACC;
      EXT_ACC: state_nxt = EXT_RSP;
      EXT_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_req   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (go_ext) begin
      lat_req   <= ext_req;
      lat_we    <= ext_we;
      lat_addr  <= ext_addr;
      lat_wdata <= ext_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ext_rdata <= '0;
    else if (state == EXT_ACC)
      ext_rdata <= mem_rdata;
  end

  // rst gates the write enable so an in-flight access dies without waiting for a clock.
  always_comb begin
    mem_we     = rst & cpu_req & cpu_we;
    mem_func3  = cpu_func3;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    cpu_rdata  = mem_rdata;
    cpu_stall  = 1'b0;
    ext_gnt    = 1'b0;
    ext_rvalid = 1'b0;
    case (state)
      EXT_ACC: begin
        mem_we    = rst & lat_req & lat_we;
        mem_func3 = 3'b010;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        ext_gnt   = 1'b1;
        cpu_stall = cpu_req;
      end
      EXT_RSP: ext_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word memory behind the port, a transaction-level
// model checked every falling edge, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
  localparam int SM = 4;
  localparam int CW = $clog2(SM + 1);

  logic          clk, rst;
  logic          cpu_req, cpu_we;
  logic [2:0]    cpu_func3;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [31:0]   ext_addr, ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [31:0]   ext_rdata;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_starve_cnt;

  dmem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_func3(cpu_func3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory attached to the port (word granularity)
  logic [31:0] dmem [0:255];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[9:2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: pending external transaction + shadow memory
  bit          cmp_en;
  int          m_phase;      // 0 = CPU owns port, 1 = external access, 2 = external response
  int          m_losses;     // consecutive arbitration losses of a waiting external request
  bit          m_last_ext;
  logic        m_x_we;
  logic [31:0] m_x_addr, m_x_wdata, m_ext_rdata;
  logic [31:0] ref_mem [0:255];
  bit          win;

  initial begin
    m_phase = 0; m_losses = 0; m_last_ext = 0;
    m_x_we = 0; m_x_addr = '0; m_x_wdata = '0; m_ext_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      if (!rst) begin
        m_phase = 0; m_losses = 0; m_last_ext = 0;
        m_x_we = 0; m_x_addr = '0; m_x_wdata = '0; m_ext_rdata = '0;
        if (cmp_en) begin
          check("rst_mem_we", mem_we, 0);
          check("rst_stall", cpu_stall, 0);
          check("rst_gnt", ext_gnt, 0);
          check("rst_rvalid", ext_rvalid, 0);
          check("rst_ext_rdata", ext_rdata, 0);
          check("rst_starve", dbg_starve_cnt, 0);
        end
      end else if (cmp_en) begin
        if (m_phase == 1) begin
          check("acc_mem_we", mem_we, m_x_we);
          check("acc_mem_addr", mem_addr, m_x_addr);
          check("acc_mem_wdata", mem_wdata, m_x_wdata);
          check("acc_func3", mem_func3, 3'b010);
          check("acc_gnt", ext_gnt, 1);
          check("acc_stall", cpu_stall, cpu_req);
          check("acc_rvalid", ext_rvalid, 0);
        end else begin
          check("cpu_mem_we", mem_we, cpu_req & cpu_we);
          check("cpu_mem_addr", mem_addr, cpu_addr);
          check("cpu_mem_wdata", mem_wdata, cpu_wdata);
          check("cpu_func3", mem_func3, cpu_func3);
          check("cpu_stall", cpu_stall, 0);
          check("cpu_gnt", ext_gnt, 0);
          check("rvalid", ext_rvalid, m_phase == 2);
          if (cpu_req && !cpu_we) check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
        end
        check("ext_rdata", ext_rdata, m_ext_rdata);
        check("starve_cnt", dbg_starve_cnt, m_losses);
        // advance to the state after the coming rising edge
        case (m_phase)
          1: begin
            m_ext_rdata = ref_mem[m_x_addr[9:2]];
            if (m_x_we) ref_mem[m_x_addr[9:2]] = m_x_wdata;
            m_phase = 2;
          end
          2: begin
            if (cpu_req && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
            m_phase = 0;
          end
          default: begin
            if (cpu_req && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            win = ext_req && (!cpu_req || !m_last_ext);
            if (ext_req || cpu_req) m_last_ext = win;
`else
            win = ext_req && (!cpu_req || m_losses == SM);
            if (!win && ext_req && cpu_req && m_losses < SM) m_losses++;
`endif
            if (win) begin
              m_phase = 1; m_losses = 0;
              m_x_we = ext_we; m_x_addr = ext_addr; m_x_wdata = ext_wdata;
            end
          end
        endcase
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_func3 = 3'b010; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wdata;
  endtask

  logic [13:0] stall_v;
  logic [CW-1:0] starve_at4, starve_or;
  logic [3:0] tbl [0:11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmp_en = 0; mem_clr = 1; rst = 1;
    cpu_drive(0, 0, 0, 0);
    ext_drive(0, 0, 0, 0);
    #2 rst = 0;
    #1 cmp_en = 1;
    repeat (3) tick();
    check("reset_state", dbg_state, 0);
    check("reset_gnt", ext_gnt, 0);
    check("reset_ext_rdata", ext_rdata, 0);
    rst = 1; mem_clr = 0;
    tick();

    // CPU only: write then read back
    cpu_drive(1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    check("t1_mem_we", mem_we, 1);
    check("t1_stall", cpu_stall, 0);
    tick();
    cpu_drive(1, 0, 32'h10, 0);
    #1;
    check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    cpu_drive(0, 0, 0, 0);

    // external read with CPU idle
    ext_drive(1, 0, 32'h10, 0);
    #1;
    check("t2_gnt_c0", ext_gnt, 0);
    tick();
    check("t2_gnt_c1", ext_gnt, 1);
    check("t2_stall_c1", cpu_stall, 0);
    check("t2_func3_c1", mem_func3, 3'b010);
    ext_drive(0, 0, 0, 0);
    tick();
    check("t2_rvalid_c2", ext_rvalid, 1);
    check("t2_rdata_c2", ext_rdata, 32'hDEADBEEF);
    tick();
    check("t2_rvalid_c3", ext_rvalid, 0);
    check("t2_rdata_hold", ext_rdata, 32'hDEADBEEF);

    // contention
    cpu_drive(1, 0, 32'h10, 0);
    tick();
    ext_drive(1, 0, 32'h10, 0);
    stall_v = '0; starve_at4 = '0; starve_or = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 12; i++) begin
      #1;
      stall_v[i] = cpu_stall;
      starve_or = starve_or | dbg_starve_cnt;
      tick();
    end
    check("t3_rr_stalls", {18'b0, stall_v}, 32'h222);
    check("t3_rr_starve", starve_or, 0);
`else
    for (int i = 0; i < 14; i++) begin
      #1;
      stall_v[i] = cpu_stall;
      if (i == 4) starve_at4 = dbg_starve_cnt;
      tick();
    end
    check("t3_stalls", {18'b0, stall_v}, 32'h1020);
    check("t3_starve_at4", starve_at4, 4);
`endif
    cpu_drive(0, 0, 0, 0);
    ext_drive(0, 0, 0, 0);
    repeat (3) tick();

    // reset during an external write
    cpu_drive(1, 1, 32'h20, 32'hA5A5A5A5);
    tick();
    cpu_drive(0, 0, 0, 0);
    ext_drive(1, 1, 32'h20, 32'h0BADF00D);
    tick();
    check("t4_acc_we", mem_we, 1);
    check("t4_acc_addr", mem_addr, 32'h20);
    rst = 0;
    ext_drive(0, 0, 0, 0);
    #1;
    check("t4_we_dropped", mem_we, 0);
    check("t4_gnt_dropped", ext_gnt, 0);
    check("t4_state_rst", dbg_state, 0);
    repeat (2) tick();
    rst = 1;
    #1;
    check("t4_state_idle", dbg_state, 0);
    check("t4_no_rvalid0", ext_rvalid, 0);
    tick();
    check("t4_no_rvalid1", ext_rvalid, 0);
    cpu_drive(1, 0, 32'h20, 0);
    #1;
    check("t4_mem_kept", cpu_rdata, 32'hA5A5A5A5);
    tick();
    cpu_drive(0, 0, 0, 0);

    // external write then CPU load
    ext_drive(1, 1, 32'h40, 32'h12345678);
    tick();
    check("t5_func3", mem_func3, 3'b010);
    check("t5_we", mem_we, 1);
    check("t5_addr", mem_addr, 32'h40);
    ext_drive(0, 0, 0, 0);
    tick();
    check("t5_rvalid", ext_rvalid, 1);
    check("t5_old_rdata", ext_rdata, 0);
    tick();
    cpu_drive(1, 0, 32'h40, 0);
    #1;
    check("t5_cpu_load", cpu_rdata, 32'h12345678);
    tick();

    // mixed directed table {cpu_req, cpu_we, ext_req, ext_we}; model checks each cycle
    tbl[0] = 4'b1010; tbl[1] = 4'b1010; tbl[2] = 4'b0010; tbl[3] = 4'b1100;
    tbl[4] = 4'b1100; tbl[5] = 4'b0000; tbl[6] = 4'b1011; tbl[7] = 4'b0011;
    tbl[8] = 4'b1000; tbl[9] = 4'b1000; tbl[10] = 4'b1110; tbl[11] = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      cpu_drive(tbl[i][3], tbl[i][2], 32'h80 + 32'(i % 4) * 4, 32'h5000_0000 + 32'(i));
      ext_drive(tbl[i][1], tbl[i][0], 32'h80 + 32'((i + 1) % 4) * 4, 32'h6000_0000 + 32'(i));
      tick();
    end
    cpu_drive(0, 0, 0, 0);
    ext_drive(0, 0, 0, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive IDLE cycles a pending external request loses to the CPU.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory-stage access valid.
- cpu_we  in  1  CPU write.
- cpu_func3  in  3  CPU store/load size code.
- cpu_addr, cpu_wdata  in  32  CPU address and write data.
- cpu_rdata  out  32  CPU read data.
- cpu_stall  out  1  CPU must hold memory stage.
- ext_req  in  1  external request; held stable until ext_gnt.
- ext_we  in  1  external write.
- ext_addr, ext_wdata  in  32  external address and write data.
- ext_gnt  out  1  external request accepted.
- ext_rvalid  out  1  external access complete.
- ext_rdata  out  32  registered external read data.
- mem_we  out  1  data memory write enable.
- mem_func3  out  3  data memory size code.
- mem_addr, mem_wdata  out  32  data memory address and write data.
- mem_rdata  in  32  data memory combinational read data.

Function
REQ-003 SHALL implement states IDLE, EXT_ACC and EXT_RSP; EXT_ACC always goes to EXT_RSP, and EXT_RSP always goes to IDLE.
REQ-004 In IDLE and EXT_RSP, the memory port SHALL be driven by the CPU:
- mem_we = cpu_req & cpu_we.
- mem_func3, mem_addr and mem_wdata pass through from the CPU.
- cpu_rdata = mem_rdata.
- cpu_stall = 0.
REQ-005 IDLE SHALL go to EXT_ACC when ext_req & (!cpu_req | starve_cnt == STARVE_MAX); ext_req, ext_we, ext_addr and ext_wdata SHALL be latched on that edge.
REQ-006 In IDLE, the CPU access SHALL complete in the same cycle even when an external request wins the arbitration.
REQ-007 In EXT_ACC:
- the memory port SHALL use the latched external fields.
- mem_func3 SHALL be 3'b010 (word).
- ext_gnt SHALL be 1 for exactly that cycle.
- cpu_stall SHALL equal cpu_req.
- mem_rdata SHALL be registered into ext_rdata.
REQ-008 ext_rvalid SHALL be 1 for exactly the EXT_RSP cycle, for both reads and writes.
REQ-009 ext_rdata SHALL hold its value until the next EXT_ACC.
REQ-010 ext_req SHALL be ignored in EXT_ACC and EXT_RSP, so the minimum spacing between external grants is 3 cycles.
REQ-011 starve_cnt (width clog2(STARVE_MAX+1)) SHALL behave as follows:
- increment, saturating at STARVE_MAX, in each IDLE cycle with ext_req & cpu_req and no transition to EXT_ACC.
- clear on entry to EXT_ACC.
- hold otherwise.
REQ-012 When ext_req is 0, the CPU SHALL never be stalled; with continuous requests from both sides, the CPU SHALL lose at most 1 of every STARVE_MAX+3 cycles.

Reset
REQ-013 While rst = 0, the block SHALL hold the following regardless of clk:
- state = IDLE and starve_cnt = 0.
- ext_gnt = 0, ext_rvalid = 0, ext_rdata = 0.
- mem_we = 0 and cpu_stall = 0.
- latched external fields = 0.
REQ-014 Reset asserted during EXT_ACC SHALL abort the access: mem_we falls to 0 immediately and no ext_rvalid follows.
REQ-015 After reset deassertion, the first arbitration decision SHALL occur on the first rising clk edge.

Configuration
REQ-016 With macro DMEM_ARB_ROUND_ROBIN_EN defined:
- the IDLE decision on simultaneous ext_req and cpu_req SHALL alternate using a last_owner flag (reset = CPU).
- the external side SHALL win if the previous winner was the CPU.
- starve_cnt SHALL be held at 0 and STARVE_MAX SHALL be unused.
REQ-017 With DMEM_ARB_ROUND_ROBIN_EN undefined, arbitration SHALL follow REQ-005 and REQ-011 exactly.

Verification
REQ-018 Bench SHALL cover, with DMEM_ARB_ROUND_ROBIN_EN undefined unless stated:
- CPU only: cpu_req = 1, cpu_we = 1, addr 0x10, wdata 0xDEADBEEF, func3 010 -> mem_we = 1 same cycle, cpu_stall = 0; a read of 0x10 next cycle -> cpu_rdata = 0xDEADBEEF.
- External read, CPU idle: ext_req with addr 0x10 -> ext_gnt in cycle +1, ext_rvalid in cycle +2, ext_rdata = 0xDEADBEEF; no stall.
- Contention: cpu_req and ext_req held high, STARVE_MAX = 4 -> CPU served 4 IDLE cycles plus the IDLE cycle at starve_cnt = 4, then EXT_ACC with cpu_stall = 1 for 1 cycle; pattern repeats every 7 cycles.
- Reset mid-operation: rst low in EXT_ACC with ext_we = 1, addr 0x20 -> mem_we = 0 immediately, location 0x20 unchanged, no ext_rvalid; state = IDLE after release.
- Round-robin build, both requesting continuously -> grants alternate CPU, external, CPU; starve_cnt reads 0 throughout.
- External write 0x12345678 to 0x40, then CPU load from 0x40 -> cpu_rdata = 0x12345678; mem_func3 = 010 during EXT_ACC.
